// File: rtl/bfm_ahblite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : bfm_ahblite_cmd_master
// Brief    : AHB-Lite initiator. Turns single-transfer commands into pipelined
//            NONSEQ/SINGLE transfers and returns one response per command.
// Revision : 1.0 - initial release
// ============================================================================
module bfm_ahblite_cmd_master #(
    parameter int AWIDTH = 10,
    parameter int TPD    = 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    output logic [AWIDTH-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic              HMASTLOCK,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [1:0]        CMD_SIZE,
    input  logic [31:0]       CMD_WDATA,
    output logic              RSP_VALID,
    output logic              RSP_ERR,
    output logic [31:0]       RSP_RDATA,
    output logic              BUSY,
    output logic [15:0]       XFER_CNT
);

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

    // TPD only shapes clock-to-out in behavioural models; it has no hardware meaning.
    if (TPD < 0) begin : g_tpd_range
    end

    // Address-phase slot
    logic              r_a_valid;
    logic              r_a_write;
    logic [AWIDTH-1:0] r_a_addr;
    logic [1:0]        r_a_size;
    logic [31:0]       r_a_wdata;
    // Data-phase slot
    logic              r_d_valid;
    logic              r_d_write;
    logic [1:0]        r_d_lane;
    logic [1:0]        r_d_size;
    logic [31:0]       r_d_wdata;

    logic              r_err1;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic [15:0]       r_xfer_cnt;

    logic              w_cmd_accept;
    logic              w_d_done;
    logic [1:0]        w_cmd_size;
    logic [31:0]       w_cmd_wdata;
    logic [31:0]       w_rd_lane;

    assign CMD_READY    = !HRESET && !r_err1 && (!r_a_valid || HREADY);
    assign w_cmd_accept = CMD_VALID && CMD_READY;
    assign w_d_done     = r_d_valid && HREADY;
    assign w_cmd_size   = (CMD_SIZE == 2'b11) ? 2'b10 : CMD_SIZE;

    // Narrow writes are replicated across all byte lanes so any slave lane decode works.
    always_comb begin
        w_cmd_wdata = CMD_WDATA;
        case (w_cmd_size)
            2'b00:   w_cmd_wdata = {4{CMD_WDATA[7:0]}};
            2'b01:   w_cmd_wdata = {2{CMD_WDATA[15:0]}};
            default: w_cmd_wdata = CMD_WDATA;
        endcase
    end

    always_comb begin
        w_rd_lane = HRDATA;
        case (r_d_size)
            2'b00:   w_rd_lane = {24'd0, HRDATA[{r_d_lane, 3'b000} +: 8]};
            2'b01:   w_rd_lane = {16'd0, HRDATA[{r_d_lane[1], 4'b0000} +: 16]};
            default: w_rd_lane = HRDATA;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_a_valid   <= 1'b0;
            r_a_write   <= 1'b0;
            r_a_addr    <= '0;
            r_a_size    <= 2'b00;
            r_a_wdata   <= '0;
            r_d_valid   <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_lane    <= 2'b00;
            r_d_size    <= 2'b00;
            r_d_wdata   <= '0;
            r_err1      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_d_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err1;
                r_rsp_rdata <= (r_d_write || r_err1) ? 32'd0 : w_rd_lane;
                r_xfer_cnt  <= r_xfer_cnt + 16'd1;
            end

            // Second ERROR cycle retires D only; the pending address stays in A.
            if (r_err1) begin
                if (HREADY) begin
                    r_err1    <= 1'b0;
                    r_d_valid <= 1'b0;
                end
            end else if (HREADY) begin
                r_d_valid <= r_a_valid;
                if (r_a_valid) begin
                    r_d_write <= r_a_write;
                    r_d_lane  <= r_a_addr[1:0];
                    r_d_size  <= r_a_size;
                    if (r_a_write) begin
                        r_d_wdata <= r_a_wdata;
                    end
                end
            end else if (r_d_valid && HRESP) begin
                r_err1 <= 1'b1;
            end

            if (w_cmd_accept) begin
                r_a_valid <= 1'b1;
                r_a_write <= CMD_WRITE;
                r_a_addr  <= CMD_ADDR;
                r_a_size  <= w_cmd_size;
                r_a_wdata <= w_cmd_wdata;
            end else if (HREADY && !r_err1) begin
                r_a_valid <= 1'b0;
            end
        end
    end

    assign HADDR     = r_a_addr;
    assign HWRITE    = r_a_write;
    assign HSIZE     = {1'b0, r_a_size};
    assign HTRANS    = (r_a_valid && !r_err1) ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HWDATA    = r_d_wdata;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ERR   = r_rsp_err;
    assign RSP_RDATA = r_rsp_rdata;
    assign BUSY      = r_a_valid || r_d_valid;
    assign XFER_CNT  = r_xfer_cnt;

endmodule
`default_nettype wire
